async_counter: RTL and testbench

ASYNC_COUNTER -- requirements
Module: async_counter

---
 rtl/async_counter_pkg.sv | 6 +
 rtl/async_counter_t_ff.sv | 14 +
 rtl/async_counter.sv | 32 +++
 tb/tb_async_counter.sv | 95 +++++++++
 4 files changed

// File: rtl/async_counter_pkg.sv
// async_counter_pkg: shared width default and reset-value constants for the ripple down counter
package async_counter_pkg;
    localparam int width_def = 4;
    localparam logic [width_def-1:0] all_ones = '1;
    localparam logic [width_def-1:0] zero = '0;
endpackage

// File: rtl/async_counter_t_ff.sv
// t_ff: toggle flip-flop with asynchronous active-high clear and inverted output
module t_ff (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qbar
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else if (t) q <= ~q;
    end
    assign qbar = ~q;
endmodule

// File: rtl/async_counter.sv
// async_counter: ripple down counter, each stage clocked by the rising edge of the previous stage's q
module async_counter
    import async_counter_pkg::*;
#(
    parameter int WIDTH = width_def
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] countbar
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            t_ff u_t_ff (
                .clk(clk),
                .rst(rst),
                .t(1'b1),
                .q(count[i]),
                .qbar(countbar[i])
            );
        end else begin : g_ripple
            // a rising q below means that bit just borrowed, so this bit flips
            t_ff u_t_ff (
                .clk(count[i-1]),
                .rst(rst),
                .t(1'b1),
                .q(count[i]),
                .qbar(countbar[i])
            );
        end
    end
endmodule

// File: tb/tb_async_counter.sv
// tb_async_counter: directed table-driven checks of the ripple down counter plus reset corner cases
`timescale 1ns/1ps
module tb_async_counter;
    import async_counter_pkg::*;

    typedef struct {
        logic [3:0] count;
        logic [3:0] countbar;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count;
    logic [3:0] countbar;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl [20];
    logic [3:0] prev;

    async_counter #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .count(count),
        .countbar(countbar)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // countbar must mirror count whenever the ripple has settled (every 2 ns, never on a rising edge)
    always begin
        #2;
        check("invariant", countbar, ~count);
    end

    initial begin
        tbl[0]  = '{4'd15, 4'd0};  tbl[1]  = '{4'd14, 4'd1};  tbl[2]  = '{4'd13, 4'd2};
        tbl[3]  = '{4'd12, 4'd3};  tbl[4]  = '{4'd11, 4'd4};  tbl[5]  = '{4'd10, 4'd5};
        tbl[6]  = '{4'd9,  4'd6};  tbl[7]  = '{4'd8,  4'd7};  tbl[8]  = '{4'd7,  4'd8};
        tbl[9]  = '{4'd6,  4'd9};  tbl[10] = '{4'd5,  4'd10}; tbl[11] = '{4'd4,  4'd11};
        tbl[12] = '{4'd3,  4'd12}; tbl[13] = '{4'd2,  4'd13}; tbl[14] = '{4'd1,  4'd14};
        tbl[15] = '{4'd0,  4'd15}; tbl[16] = '{4'd15, 4'd0};  tbl[17] = '{4'd14, 4'd1};
        tbl[18] = '{4'd13, 4'd2};  tbl[19] = '{4'd12, 4'd3};

        #1;
        check("reset_count_t1", count, zero);
        check("reset_countbar_t1", countbar, all_ones);
        @(posedge clk); #1;
        check("reset_count_edge5", count, zero);
        check("reset_countbar_edge5", countbar, all_ones);
        @(posedge clk); #1;
        check("reset_count_edge15", count, zero);
        check("reset_countbar_edge15", countbar, all_ones);
        #7 rst = 1'b0;

        prev = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("tbl_count_%0d", i), count, tbl[i].count);
            check($sformatf("tbl_countbar_%0d", i), countbar, tbl[i].countbar);
            check($sformatf("decrement_%0d", i), count, prev - 4'd1);
            prev = count;
        end
        #4;
        check("long_run_count_220", count, 4'd12);
        check("long_run_countbar_220", countbar, 4'd3);

        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_count", count, 4'd9);
        #5 rst = 1'b1;
        #1;
        check("midreset_count_immediate", count, zero);
        check("midreset_countbar_immediate", countbar, all_ones);
        @(posedge clk); #1;
        check("midreset_count_held_edge", count, zero);
        #7 rst = 1'b0;
        @(posedge clk); #1;
        check("post_release_count", count, 4'd15);
        check("post_release_countbar", countbar, 4'd0);
        @(posedge clk); #1;
        check("post_release_count_2", count, 4'd14);
        #4;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
